// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data-memory responder with an always-ready debug port.
// Define DMEM_MISALIGN_CHECK_EN to reject byte enables that do not fit the address alignment.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic [3:0]  WE,
    output logic [31:0] RD,
    output logic        ack,
    output logic        stall,
    output logic        err,
    input  logic [31:0] A2,
    input  logic [31:0] WD2,
    input  logic [3:0]  WE2,
    output logic [31:0] RD2
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, we_q, we_d, cpu_we;
    logic [31:0] a_q, a_d, wd_q, wd_d, rd_q, rd_d, rd2_q;
    logic        err_q, err_d, oor, mis, wr_ok, unused;
    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0] idx, idx2;
    assign idx    = a_q[DEPTH_LOG2+1:2];
    assign idx2   = A2[DEPTH_LOG2+1:2];
    assign oor    = |a_q[31:DEPTH_LOG2+2];
    assign unused = ^{A2[31:DEPTH_LOG2+2], A2[1:0], a_q[1:0]};
`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis = !(we_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})
              || (we_q == 4'b1111 && a_q[1:0] != 2'b00)
              || ((we_q == 4'b0011 || we_q == 4'b1100) && a_q[0]);
`else
    assign mis = 1'b0;
`endif
    assign wr_ok  = state_q == ACCESS && !oor && !mis;
    assign cpu_we = {4{wr_ok}} & we_q;
    assign ack    = state_q == RESP;
    assign stall  = (state_q == IDLE && req) || state_q == WAIT || state_q == ACCESS;
    assign RD     = rd_q;
    assign err    = err_q;
    assign RD2    = rd2_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        wd_d    = wd_q;
        we_d    = we_q;
        rd_d    = rd_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (req) begin
                a_d     = A;
                wd_d    = WD;
                we_d    = WE;
                cnt_d   = 4'(WAIT_CYCLES - 1);
                state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
            end
            WAIT: begin
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? ACCESS : WAIT;
            end
            ACCESS: begin
                // read-before-write: RD returns the word as it was before this store
                rd_d    = oor ? 32'd0 : (mis ? rd_q : mem[idx]);
                err_d   = oor || mis;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            wd_q    <= 32'd0;
            we_q    <= 4'd0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
            rd2_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            rd2_q   <= mem[idx2];
        end
    end
    // CPU write is issued last so it overrides the debug port on a shared byte
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (WE2[i]) mem[idx2][8*i +: 8] <= WD2[8*i +: 8];
            if (cpu_we[i]) mem[idx][8*i +: 8] <= wd_q[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder with a reference memory model.
module tb_dmem_responder;
    localparam int DL = 10;
    localparam int WC = 2;
    logic clk = 0, rst = 1, req = 0, ack, stall, err;
    logic [31:0] A = 0, WD = 0, A2 = 0, WD2 = 0, RD, RD2;
    logic [3:0] WE = 0, WE2 = 0;
    int nvec = 0, nerr = 0;
    logic [31:0] mdl [0:(1<<DL)-1];
    logic [31:0] last_rd = 0;
    typedef struct packed {logic [31:0] rd; logic err;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req(req), .A(A), .WD(WD), .WE(WE), .RD(RD),
        .ack(ack), .stall(stall), .err(err), .A2(A2), .WD2(WD2), .WE2(WE2), .RD2(RD2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dbg_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        A2 = a; WD2 = d; WE2 = 4'hf;
        @(negedge clk);
        WE2 = 4'h0;
        mdl[a[DL+1:2]] = d;
    endtask

    task automatic cpu(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] we, input logic [3:0] dwe, input logic [31:0] dwd);
        exp_t e;
        logic [31:0] w;
        bit oor, mis;
        int n, st;
        oor = |a[31:DL+2];
        mis = 0;
`ifdef DMEM_MISALIGN_CHECK_EN
        mis = !(we inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hc, 4'hf})
           || (we == 4'hf && a[1:0] != 0) || ((we == 4'h3 || we == 4'hc) && a[0]);
`endif
        if (oor) e = '{rd: 32'd0, err: 1'b1};
        else if (mis) e = '{rd: last_rd, err: 1'b1};
        else begin
            e = '{rd: mdl[a[DL+1:2]], err: 1'b0};
            w = mdl[A2[DL+1:2]];
            for (int i = 0; i < 4; i++) if (dwe[i]) w[8*i +: 8] = dwd[8*i +: 8];
            mdl[A2[DL+1:2]] = w;
            w = mdl[a[DL+1:2]];
            for (int i = 0; i < 4; i++) if (we[i]) w[8*i +: 8] = d[8*i +: 8];
            mdl[a[DL+1:2]] = w;
        end
        last_rd = e.rd;
        sb.push_back(e);
        @(negedge clk);
        A = a; WD = d; WE = we; req = 1;
        #1 st = stall ? 1 : 0;
        n = 0;
        while (!ack && n < 50) begin
            @(negedge clk);
            n++;
            if (n == 1) begin A = ~a; WD = ~d; WE = ~we; end
            if (n == WC + 1 && dwe != 0) begin WD2 = dwd; WE2 = dwe; end
            if (stall) st++;
        end
        req = 0; WE2 = 0;
        chk({tag, "_lat"}, n, WC + 2);
        chk({tag, "_stall"}, st, WC + 2);
        e = sb.pop_front();
        chk({tag, "_rd"}, RD, e.rd);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
        @(negedge clk);
        chk({tag, "_ack1"}, {31'd0, ack}, 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_rd", RD, 0);
        chk("rst_ack", {31'd0, ack}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_rd2", RD2, 0);
        @(negedge clk);
        rst = 0;
        dbg_wr(32'h10, 32'h01020304);
        dbg_wr(32'h20, 32'hCAFEF00D);
        dbg_wr(32'hFFC, 32'h5A5A5A5A);
        dbg_wr(32'h0, 32'h0BADC0DE);
        A2 = 32'h10;
        cpu("st10", 32'h10, 32'hDEADBEEF, 4'hf, 0, 0);
        cpu("ld10", 32'h10, 0, 4'h0, 0, 0);
        cpu("sb12", 32'h12, 32'h00AA0000, 4'h4, 0, 0);
        cpu("ld10b", 32'h10, 0, 4'h0, 0, 0);
        @(negedge clk);
        chk("dbg_rd", RD2, mdl[4]);
        cpu("conf", 32'h10, 32'h22, 4'h1, 4'h3, 32'h3311);
        cpu("ldconf", 32'h10, 0, 4'h0, 0, 0);
        chk("conf_word", RD, 32'hDEAA3322);
        cpu("ldlast", 32'hFFC, 0, 4'h0, 0, 0);
        cpu("oor1000", 32'h1000, 32'h1111, 4'hf, 0, 0);
        cpu("oor8000", 32'h80000000, 0, 4'h0, 0, 0);
        cpu("ld0", 32'h0, 0, 4'h0, 0, 0);
        @(negedge clk);
        A = 32'h20; WD = 32'h12345678; WE = 4'hf; req = 1;
        repeat (2) @(negedge clk);
        chk("wait_stall", {31'd0, stall}, 1);
        rst = 1; req = 0;
        #1;
        chk("mrst_rd", RD, 0);
        chk("mrst_ack", {31'd0, ack}, 0);
        chk("mrst_stall", {31'd0, stall}, 0);
        chk("mrst_rd2", RD2, 0);
        chk("mrst_err", {31'd0, err}, 0);
        last_rd = 0;
        @(negedge clk);
        rst = 0;
        cpu("ld20", 32'h20, 0, 4'h0, 0, 0);
        cpu("mis21", 32'h21, 32'h77777777, 4'hf, 0, 0);
        cpu("ld20b", 32'h20, 0, 4'h0, 0, 0);
        cpu("mis23", 32'h23, 32'h00005500, 4'h3, 0, 0);
        cpu("ld20c", 32'h20, 0, 4'h0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
